// File: rtl/set_ex_stage.sv
// Two-stage execute slice for the DLX set-on-compare instructions.
// Operands are latched in S1, and the registered 0/1 result is presented from S2.
module set_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] a_in,
  input  logic [0:31] b_in,
  input  logic [0:2]  func_in,
  input  logic [0:4]  rd_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] result,
  output logic [0:4]  rd_out,
  output logic        wr_en,
  output logic        bad_func
);

  logic        s1_valid_r;
  logic [0:31] a_r;
  logic [0:31] b_r;
  logic [0:2]  func_r;
  logic [0:4]  rd_r;

  logic        out_valid_r;
  logic [0:31] result_r;
  logic [0:4]  rd_out_r;
  logic        wr_en_r;
  logic        bad_func_r;

  logic        s2_adv_s;
  logic        s1_adv_s;
  logic        s1_load_s;
  logic [0:1]  eval_s;
  logic        legal_s;
  logic        cond_s;

  // Signed compare through the subtract path; returns {legal, condition}.
  function automatic logic [0:1] eval_cond(input logic [0:31] a,
                                           input logic [0:31] b,
                                           input logic [0:2]  f);
    logic [0:31] diff;
    logic        ovf;
    logic        eq;
    logic        lt;
    logic        cond;
    logic        legal;
    diff  = a + ~b + 32'd1;
    ovf   = (a[0] != b[0]) & (diff[0] != a[0]);
    eq    = (diff == 32'd0);
    lt    = diff[0] ^ ovf;
    legal = 1'b1;
    case (f)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b010:  cond = lt;
      3'b011:  cond = ~(lt | eq);
      3'b100:  cond = lt | eq;
      3'b101:  cond = ~lt;
      default: begin
        cond  = 1'b0;
        legal = 1'b0;
      end
    endcase
    return {legal, cond};
  endfunction

  // Handshake and advance decisions.
  always_comb begin
    s2_adv_s  = ~out_valid_r | out_ready;
    s1_adv_s  = s2_adv_s;
    in_ready  = ~s1_valid_r | s1_adv_s;
    s1_load_s = in_valid & in_ready;
    eval_s    = eval_cond(a_r, b_r, func_r);
    legal_s   = eval_s[0];
    cond_s    = eval_s[1] & legal_s;
  end

  // Stage 1 operand latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      func_r     <= 3'd0;
      rd_r       <= 5'd0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      a_r        <= a_in;
      b_r        <= b_in;
      func_r     <= func_in;
      rd_r       <= rd_in;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2 result register; flush keeps stale data but drops the qualifiers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      rd_out_r    <= 5'd0;
      wr_en_r     <= 1'b0;
      bad_func_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      wr_en_r     <= 1'b0;
      bad_func_r  <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      result_r    <= {31'd0, cond_s};
      rd_out_r    <= rd_r;
      wr_en_r     <= s1_valid_r & legal_s & (rd_r != 5'd0);
      bad_func_r  <= s1_valid_r & ~legal_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign rd_out    = rd_out_r;
  assign wr_en     = wr_en_r;
  assign bad_func  = bad_func_r;

endmodule

// File: tb/tb_set_ex_stage.sv
// Directed self-checking bench for set_ex_stage.
module tb_set_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] a_in;
  logic [0:31] b_in;
  logic [0:2]  func_in;
  logic [0:4]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] result;
  logic [0:4]  rd_out;
  logic        wr_en;
  logic        bad_func;

  int checks;
  int errors;

  set_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .func_in   (func_in),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .wr_en     (wr_en),
    .bad_func  (bad_func)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [4:0] rd);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    func_in  = f;
    rd_in    = rd;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Issue one instruction into an empty, free-flowing pipe and check it.
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, input logic [4:0] rd,
                      input logic exp_res, input logic exp_wr, input logic exp_bad);
    drive(a, b, f, rd);
    tick();
    idle();
    tick();
    chk({tag, "_valid"}, out_valid, 32'd1);
    chk({tag, "_result"}, result, {31'd0, exp_res});
    chk({tag, "_rd"}, rd_out, rd);
    chk({tag, "_wr_en"}, wr_en, exp_wr);
    chk({tag, "_bad"}, bad_func, exp_bad);
    tick();
    chk({tag, "_drain"}, out_valid, 32'd0);
  endtask

  initial begin
    logic [5:0] stream_exp;
    checks    = 0;
    errors    = 0;
    stream_exp = 6'b110001;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = 32'd0;
    b_in      = 32'd0;
    func_in   = 3'd0;
    rd_in     = 5'd0;

    tick();
    tick();
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", rd_out, 32'd0);
    chk("rst_wr_en", wr_en, 32'd0);
    chk("rst_bad_func", bad_func, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    rst_n = 1'b1;

    // Back-to-back stream a=b=5 over all legal funcs.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(32'd5, 32'd5, i[2:0], 5'(i + 1));
      else idle();
      chk("stream_in_ready", in_ready, 32'd1);
      tick();
      if (i >= 1 && i <= 6) begin
        chk("stream_valid", out_valid, 32'd1);
        chk("stream_result", result, {31'd0, stream_exp[i - 1]});
        chk("stream_rd", rd_out, 32'(i));
        chk("stream_wr_en", wr_en, 32'd1);
      end
    end
    chk("stream_drain", out_valid, 32'd0);

    run1("slt_ovf", 32'h80000000, 32'h00000001, 3'b010, 5'd3, 1'b1, 1'b1, 1'b0);
    run1("sgt_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b011, 5'd4, 1'b1, 1'b1, 1'b0);
    run1("sge_neg", 32'hFFFFFFFF, 32'h00000000, 3'b101, 5'd5, 1'b0, 1'b1, 1'b0);
    run1("illegal", 32'd5, 32'd5, 3'b110, 5'd7, 1'b0, 1'b0, 1'b1);
    run1("illegal7", 32'd1, 32'd2, 3'b111, 5'd8, 1'b0, 1'b0, 1'b1);
    run1("seq_rd0", 32'd9, 32'd9, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: three offered, two absorbed, then released in order.
    out_ready = 1'b0;
    drive(32'd1, 32'd1, 3'b000, 5'd2);
    chk("bp_rdy_a", in_ready, 32'd1);
    tick();
    drive(32'd1, 32'd2, 3'b001, 5'd3);
    chk("bp_rdy_b", in_ready, 32'd1);
    tick();
    drive(32'd3, 32'd2, 3'b010, 5'd4);
    chk("bp_rdy_c", in_ready, 32'd0);
    chk("bp_out_a", rd_out, 32'd2);
    chk("bp_res_a", result, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_rdy", in_ready, 32'd0);
      chk("bp_hold_valid", out_valid, 32'd1);
      chk("bp_hold_rd", rd_out, 32'd2);
      chk("bp_hold_res", result, 32'd1);
      chk("bp_hold_wr", wr_en, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 32'd1);
    tick();
    idle();
    chk("bp_out_b_valid", out_valid, 32'd1);
    chk("bp_out_b_rd", rd_out, 32'd3);
    chk("bp_out_b_res", result, 32'd1);
    tick();
    chk("bp_out_c_valid", out_valid, 32'd1);
    chk("bp_out_c_rd", rd_out, 32'd4);
    chk("bp_out_c_res", result, 32'd0);
    tick();
    chk("bp_empty", out_valid, 32'd0);

    // Flush with two in flight and a concurrent input.
    out_ready = 1'b0;
    drive(32'd5, 32'd5, 3'b000, 5'd5);
    tick();
    drive(32'd5, 32'd6, 3'b001, 5'd6);
    tick();
    chk("fl_pre_valid", out_valid, 32'd1);
    flush = 1'b1;
    drive(32'd7, 32'd7, 3'b000, 5'd9);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_valid", out_valid, 32'd0);
    chk("fl_wr_en", wr_en, 32'd0);
    chk("fl_bad", bad_func, 32'd0);
    chk("fl_in_ready", in_ready, 32'd1);
    tick();
    chk("fl_s1_empty", out_valid, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", out_valid, 32'd0);
    run1("fl_fresh", 32'd2, 32'd1, 3'b101, 5'd6, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    drive(32'd4, 32'd4, 3'b000, 5'd10);
    tick();
    drive(32'd4, 32'd4, 3'b101, 5'd11);
    tick();
    idle();
    chk("mr_pre_rdy", in_ready, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", out_valid, 32'd0);
    chk("mr_result", result, 32'd0);
    chk("mr_rd", rd_out, 32'd0);
    chk("mr_wr_en", wr_en, 32'd0);
    chk("mr_bad", bad_func, 32'd0);
    chk("mr_in_ready", in_ready, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("mr_no_stale1", out_valid, 32'd0);
    tick();
    chk("mr_no_stale2", out_valid, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_ex_stage.md
# set_ex_stage

Two-stage pipelined execute slice for DLX set-on-compare instructions (SEQ, SNE, SLT, SGT, SLE, SGE). Sits directly downstream of the ID/EX operand latch and feeds the EX/MEM boundary. It registers the operands, evaluates the signed compare through the standard 32-bit subtract path, and presents a registered 0/1 word result with its destination register. Valid/ready stall handling and a pipeline flush are built in.

## Interface
- No parameters. Width is fixed at 32 bits; register index is 5 bits. All vectors use [0:N] ordering, with bit 0 as the MSB.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  kills all in-flight entries; has priority over everything except reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage 1 can accept this cycle
- a_in  in  [0:31]  operand A (rs1)
- b_in  in  [0:31]  operand B (rs2 or sign-extended immediate)
- func_in  in  [0:2]  000 SEQ, 001 SNE, 010 SLT, 011 SGT, 100 SLE, 101 SGE, 110/111 illegal
- rd_in  in  [0:4]  destination register
- out_valid  out  1  result entry valid
- out_ready  in  1  downstream accepts the entry
- result  out  [0:31]  32'h00000001 if the condition is true, else 32'h00000000
- rd_out  out  [0:4]  destination register
- wr_en  out  1  1 only if the entry is valid, func is legal, and rd_out != 0
- bad_func  out  1  entry carries an illegal func; result is forced to 0 and wr_en to 0

## Operation
- Stage 1 (S1) holds: s1_valid, a, b, func, rd.
- Stage 2 (S2) holds: out_valid, result, rd_out, wr_en, bad_func.
- Advance conditions:
  - s2_adv = !out_valid | out_ready
  - s1_adv = s2_adv
  - in_ready = !s1_valid | s1_adv
- S1 load: if in_valid & in_ready, capture the inputs and set s1_valid = 1.
- S1 drain: if S1 advances and nothing loads, s1_valid = 0.
- S1 hold: if S1 is stalled, all S1 contents hold.
- S2 load: when s2_adv, load from S1 and set out_valid = s1_valid. When stalled, S2 holds all outputs stable.
- Compare, computed combinationally from S1:
  - diff = a + ~b + 1 (32-bit, carry discarded)
  - ovf = (a[0] != b[0]) & (diff[0] != a[0])
  - eq = (diff == 0)
  - lt = diff[0] ^ ovf
  - The compare is signed two's-complement for all funcs.
- Condition per func:
  - SEQ = eq
  - SNE = !eq
  - SLT = lt
  - SGE = !lt
  - SLE = lt | eq
  - SGT = !(lt | eq)
- Result word: bits [0:30] are 0; bit 31 is the condition.
- Illegal func (110/111): result = 0, bad_func = 1, wr_en = 0. The entry still flows through the pipeline and is not dropped.
- Flush: at the clock edge, s1_valid = 0 and out_valid = 0. Any in_valid in the same cycle is discarded. Datapath registers may keep stale values, but wr_en and bad_func are cleared with out_valid.
- Reset: rst_n low at an edge clears s1_valid, out_valid, result, rd_out, wr_en, and bad_func to 0. in_ready then reads 1. Asserting reset mid-stall discards all entries.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N+1 (2-cycle register-to-register).
- Throughput: 1 instruction per cycle when out_ready stays high.
- in_ready is combinational from out_ready and the internal valids. There is no combinational path from in_valid to out_valid.
- Handshake: transfer occurs only when valid & ready are both high at a rising edge. While out_valid = 1 and out_ready = 0, result, rd_out, wr_en, and bad_func are held constant.
- Back-pressure: with out_ready low, the pipeline absorbs at most 2 entries (S1 + S2). in_ready then drops in the same cycle S1 is full and blocked.
- Simultaneous out_ready rise with a full pipe: S2 is consumed, S1 moves into S2, and a new input is accepted, all on one edge.

## Test plan
- Reset then stream: drive 6 back-to-back instructions with out_ready = 1 and a = 5, b = 5, func = 000..101. Required outputs 2 cycles later: 1, 0, 0, 0, 1, 1. in_ready stays 1 throughout.
- Signed/overflow: a = 32'h80000000, b = 32'h00000001, SLT -> result 1. a = 32'h7FFFFFFF, b = 32'hFFFFFFFF, SGT -> result 1. a = 32'hFFFFFFFF, b = 0, SGE -> result 0.
- Back-pressure: hold out_ready = 0 and offer 3 instructions. Only 2 are accepted, and in_ready goes 0 after the second. Output values stay frozen. Release out_ready; all 3 emerge in order with no loss or duplication.
- Flush: with 2 entries in flight, assert flush together with in_valid. Next cycle out_valid = 0, s1 is empty, and the concurrent input is lost. A fresh input issued afterwards emerges 2 cycles later.
- Illegal/zero-rd: func = 110, rd = 7 -> result 0, bad_func = 1, wr_en = 0. SEQ with a = b and rd = 0 -> result 1, wr_en = 0.
- Mid-stall reset: fill the pipe with out_ready = 0, then pull rst_n low for 1 edge. All outputs read 0, in_ready = 1, and no stale entry appears afterwards.
